// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcode enum and status flag bundle.
package alu_pipe_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_ACC = 3'b111
    } op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, flags and the next accumulator value.
// Define ALU_PIPE_SAT_EN for unsigned saturation of ADD, SUB and ACC-add.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags,
    output logic [WIDTH-1:0] next_acc
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   acc_w;
    logic [WIDTH-1:0] add_q;
    logic [WIDTH-1:0] sub_q;
    logic [WIDTH-1:0] acc_q;
    logic             add_ovf;
    logic             sub_ovf;
    logic             acc_ovf;

    // Extra top bit holds carry (add) or borrow (sub, wraps to 1 when a<b)
    assign add_w = (WIDTH+1)'(a) + (WIDTH+1)'(b);
    assign sub_w = (WIDTH+1)'(a) - (WIDTH+1)'(b);
    assign acc_w = (WIDTH+1)'(acc) + (WIDTH+1)'(a);

    assign add_ovf = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
    assign sub_ovf = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
    assign acc_ovf = (acc[MSB] == a[MSB]) && (acc_w[MSB] != acc[MSB]);

`ifdef ALU_PIPE_SAT_EN
    assign add_q = add_w[WIDTH] ? {WIDTH{1'b1}} : add_w[WIDTH-1:0];
    assign sub_q = sub_w[WIDTH] ? {WIDTH{1'b0}} : sub_w[WIDTH-1:0];
    assign acc_q = acc_w[WIDTH] ? {WIDTH{1'b1}} : acc_w[WIDTH-1:0];
`else
    assign add_q = add_w[WIDTH-1:0];
    assign sub_q = sub_w[WIDTH-1:0];
    assign acc_q = acc_w[WIDTH-1:0];
`endif

    // Opcode decode; zero is derived from the final (possibly clamped) result
    always_comb begin
        result   = '0;
        flags    = '0;
        next_acc = acc;
        case (op)
            OP_ADD: begin
                result      = add_q;
                flags.carry = add_w[WIDTH];
                flags.ovf   = add_ovf;
            end
            OP_SUB: begin
                result      = sub_q;
                flags.carry = sub_w[WIDTH];
                flags.ovf   = sub_ovf;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: result = a << b[SHW-1:0];
            OP_SHR: result = a >> b[SHW-1:0];
            OP_ACC: begin
                if (b[0]) begin
                    next_acc = a;
                end else begin
                    next_acc    = acc_q;
                    flags.carry = acc_w[WIDTH];
                    flags.ovf   = acc_ovf;
                end
                result = next_acc;
            end
            default: result = '0;
        endcase
        flags.zero = (result == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with a persistent accumulator.
// Saturating arithmetic is selected at build time by ALU_PIPE_SAT_EN.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q_out,
    output logic             carry_out,
    output logic             zero_out,
    output logic             ovf_out
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_q;
    alu_flags_t       s2_flags;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] core_result;
    logic [WIDTH-1:0] core_next_acc;
    alu_flags_t       core_flags;

    logic             s1_en;
    logic             s2_en;

    assign s2_en    = !s2_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en && rst;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a        (s1_a),
        .b        (s1_b),
        .op       (s1_op),
        .acc      (acc),
        .result   (core_result),
        .flags    (core_flags),
        .next_acc (core_next_acc)
    );

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a_in;
                s1_b  <= b_in;
                s1_op <= op_e'(op_in);
            end
        end
    end

    // Stage 2: result/flags; acc advances only as an ACC beat leaves S1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
            s2_flags <= '0;
            acc      <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q     <= core_result;
                s2_flags <= core_flags;
                if (s1_op == OP_ACC) begin
                    acc <= core_next_acc;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign q_out     = s2_q;
    assign carry_out = s2_flags.carry;
    assign zero_out  = s2_flags.zero;
    assign ovf_out   = s2_flags.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=8) with an in-order result scoreboard.
module tb_alu_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [2:0] op_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] q_out;
    logic       carry_out;
    logic       zero_out;
    logic       ovf_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_pop_cyc = -10;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       c;
        logic       z;
        logic       o;
        bit         chain;
    } exp_t;

    exp_t expq[$];

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .op_in     (op_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_out     (q_out),
        .carry_out (carry_out),
        .zero_out  (zero_out),
        .ovf_out   (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Results are sampled on the falling edge; out_ready is only changed just after a rising edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("extra_result", 32'(q_out), 32'hdead);
            end else begin
                e = expq.pop_front();
                check({e.tag, "_q"}, 32'(q_out), 32'(e.q));
                check({e.tag, "_c"}, 32'(carry_out), 32'(e.c));
                check({e.tag, "_z"}, 32'(zero_out), 32'(e.z));
                check({e.tag, "_o"}, 32'(ovf_out), 32'(e.o));
                if (e.chain) check({e.tag, "_gap"}, 32'(cyc - last_pop_cyc), 32'd1);
            end
            last_pop_cyc = cyc;
        end
    end

    task automatic push_exp(input string tag, input logic [7:0] q, input logic c, input logic z,
                            input logic o, input bit chain);
        exp_t e;
        e.tag = tag; e.q = q; e.c = c; e.z = z; e.o = o; e.chain = chain;
        expq.push_back(e);
    endtask

    // Offer one beat, wait (bounded) for acceptance, then drop in_valid
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input string tag, input logic [7:0] q, input logic c, input logic z,
                        input logic o, input bit track, input bit chain);
        bit ok = 0;
        op_in = op; a_in = a; b_in = b; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        if (track) push_exp(tag, q, c, z, o, chain);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && (expq.size() != 0 || out_valid); i++) @(posedge clk);
        #1;
        check({tag, "_drained"}, 32'(expq.size()), 32'd0);
    endtask

    logic [7:0] bp_a [4] = '{8'd1, 8'd3, 8'd10, 8'd0};
    logic [7:0] bp_b [4] = '{8'd2, 8'd4, 8'd20, 8'd0};
    logic [7:0] bp_q [4] = '{8'd3, 8'd7, 8'd30, 8'd0};

    initial begin
        int acc_n;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; op_in = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_q", 32'(q_out), 32'd0);
        check("rst_flags", 32'({carry_out, zero_out, ovf_out}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Arithmetic and logic vectors, computed by hand for WIDTH=8
`ifdef ALU_PIPE_SAT_EN
        send(3'b000, 8'd200, 8'd100, "add_carry", 8'd255, 1, 0, 0, 1, 0);
`else
        send(3'b000, 8'd200, 8'd100, "add_carry", 8'd44, 1, 0, 0, 1, 0);
`endif
        send(3'b000, 8'd100, 8'd100, "add_ovf", 8'd200, 0, 0, 1, 1, 0);
        send(3'b001, 8'd5, 8'd5, "sub_zero", 8'd0, 0, 1, 0, 1, 0);
`ifdef ALU_PIPE_SAT_EN
        send(3'b001, 8'd3, 8'd5, "sub_borrow", 8'd0, 1, 1, 0, 1, 0);
`else
        send(3'b001, 8'd3, 8'd5, "sub_borrow", 8'd254, 1, 0, 0, 1, 0);
`endif
        send(3'b101, 8'h81, 8'd3, "shl", 8'h08, 0, 0, 0, 1, 0);
        send(3'b110, 8'h81, 8'd9, "shr_wrap_amt", 8'h40, 0, 0, 0, 1, 0);
        send(3'b010, 8'hF0, 8'h3C, "and", 8'h30, 0, 0, 0, 1, 0);
        send(3'b011, 8'h0F, 8'hF0, "or", 8'hFF, 0, 0, 0, 1, 0);
        send(3'b100, 8'hAA, 8'hAA, "xor_zero", 8'h00, 0, 1, 0, 1, 0);
        drain("alu_ops");

        // Back-to-back accumulator chain: results on consecutive cycles
        send(3'b111, 8'd10, 8'd1, "acc_load", 8'd10, 0, 0, 0, 1, 0);
        send(3'b111, 8'd20, 8'd0, "acc_add1", 8'd30, 0, 0, 0, 1, 1);
        send(3'b111, 8'd30, 8'd0, "acc_add2", 8'd60, 0, 0, 0, 1, 1);
        drain("acc_chain");

        // Back-pressure: only two beats fit while the consumer stalls
        out_ready = 1'b0;
        acc_n = 0;
        op_in = 3'b000; a_in = bp_a[0]; b_in = bp_b[0]; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp($sformatf("bp%0d", acc_n), bp_q[acc_n], 0, (bp_q[acc_n] == 0), 0, 0);
                acc_n++;
            end
            @(posedge clk); #1;
            if (acc_n < 4) begin a_in = bp_a[acc_n]; b_in = bp_b[acc_n]; end
            else in_valid = 1'b0;
        end
        check("bp_accepted", 32'(acc_n), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_q_held", 32'(q_out), 32'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && acc_n < 4; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp($sformatf("bp%0d", acc_n), bp_q[acc_n], 0, (bp_q[acc_n] == 0), 0, 0);
                acc_n++;
            end
            @(posedge clk); #1;
            if (acc_n < 4) begin a_in = bp_a[acc_n]; b_in = bp_b[acc_n]; end
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 32'(acc_n), 32'd4);
        drain("backpressure");

        // Reset with two beats in flight and acc=60; those beats must vanish
        out_ready = 1'b0;
        send(3'b000, 8'd1, 8'd1, "inflight0", 8'd0, 0, 0, 0, 0, 0);
        send(3'b000, 8'd2, 8'd2, "inflight1", 8'd0, 0, 0, 0, 0, 0);
        check("inflight_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_q", 32'(q_out), 32'd0);
        check("midrst_flags", 32'({carry_out, zero_out, ovf_out}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        send(3'b111, 8'd5, 8'd0, "acc_after_rst", 8'd5, 0, 0, 0, 1, 0);
        drain("after_rst");
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the 8-bit combinational ALU used in the lab testbenches. It adds a configurable datapath width, valid/ready handshakes on input and output, and a two-stage registered pipeline. It also adds a persistent accumulator operation and carry, zero and overflow status flags. It sits between a stimulus/controller stage and a result consumer, and sustains one operation per cycle when not back-pressured.

## Interface
- WIDTH, 8, datapath width in bits; ≥4, power of two
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (low = in reset)
- in_valid  input  1  operand beat offered
- in_ready  output  1  block can accept a beat this cycle
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- op_in  input  3  opcode
- out_valid  output  1  result beat offered
- out_ready  input  1  consumer accepts result
- q_out  output  WIDTH  result
- carry_out  output  1  carry/borrow flag
- zero_out  output  1  q_out == 0
- ovf_out  output  1  signed overflow flag

## Operation
- Opcodes:
  - 000 ADD: q = a+b.
  - 001 SUB: q = a−b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: q = a << b[SHW-1:0].
  - 110 SHR: logical, q = a >> b[SHW-1:0].
  - 111 ACC: if b[0]=1, acc ← a; otherwise acc ← acc+a. q = new acc.
- Stage 1 (S1) registers a, b and op. Stage 2 (S2) registers the result and flags.
- carry:
  - ADD/ACC-add: carry out of the MSB.
  - SUB: borrow (a<b unsigned).
  - All other ops: 0.
- ovf:
  - ADD/ACC-add: signed overflow of a+b (or acc+a).
  - SUB: signed overflow of a−b.
  - All other ops: 0.
- zero is computed on the final q, after any saturation.
- acc is a WIDTH-bit register, reset to 0.
  - acc updates only on the cycle an ACC op moves from S1 to S2.
  - Back-to-back ACC ops therefore chain correctly with no stall.
- Arithmetic wraps modulo 2^WIDTH unless saturation is configured (see Configuration).

## Timing
- Handshakes:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en, forced 0 while rst is low.
- An input beat is transferred on a rising edge with in_valid && in_ready.
- An output beat is consumed on a rising edge with out_valid && out_ready.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+1 (the S1→S2 transfer edge), i.e. two register stages.
- Throughput: 1 beat/cycle while out_ready=1.
- Full pipeline with out_ready=0: both stages hold, in_ready=0, and q_out/flags stay stable.
- Simultaneous accept and consume on the same edge is legal and loses no beat.
- q_out and flags are registered and stable whenever out_valid=1 until consumed; their value is don't-care when out_valid=0.
- Reset (rst low, at any time, including mid-stream):
  - Immediately: out_valid=0, q_out=0, carry/zero/ovf=0, in_ready=0.
  - Both stage valids and acc clear to 0; in-flight beats are discarded.
- First edge after rst rises: in_ready=1.

## Configuration
- ALU_PIPE_SAT_EN defined: unsigned saturation.
  - ADD/ACC-add clamp to all-ones on carry.
  - SUB clamps to 0 on borrow.
  - acc stores the saturated value.
  - The carry flag still reports the raw carry/borrow.
- ALU_PIPE_SAT_EN undefined: modular wrap as described above. No saturation logic is built.

## Structure
- Package alu_pipe_pkg:
  - op_e enum (OP_ADD…OP_ACC, 3 bits).
  - alu_flags_t struct {carry, zero, ovf}.
- Sub-module alu_core: purely combinational.
  - Inputs: a, b, op, acc. Outputs: result, flags, next_acc.
  - Parametrised on WIDTH and instantiated once.
- alu_pipe owns the pipeline registers, handshake logic and acc.

## Test plan
- WIDTH=8, ADD a=200 b=100 → q=44, carry=1, ovf=0, zero=0. With ALU_PIPE_SAT_EN: q=255, carry=1. ADD 100+100 → q=200, ovf=1.
- SUB a=5 b=5 → q=0, zero=1, carry=0. SUB a=3 b=5 → q=254, carry=1 (saturated build: q=0, zero=1).
- SHL a=8'h81 b=3 → 8'h08. SHR a=8'h81 b=9 → shift by 1 → 8'h40. AND 8'hF0 & 8'h3C → 8'h30, flags 0.
- Back-to-back ACC: (a=10, b=1), (a=20, b=0), (a=30, b=0), one per cycle → q sequence 10, 30, 60 with no bubbles.
- Back-pressure: hold out_ready=0 and offer 4 ADD beats continuously → exactly 2 accepted, then in_ready=0. Release out_ready → all results delivered in order, none duplicated or lost.
- Reset mid-stream: pull rst low with 2 beats in flight and acc=60 → out_valid=0 immediately. After release, ACC (a=5, b=0) → q=5.
